// File: rtl/sp_ram_arbiter.sv
// Two-port arbiter in front of a single-port byte-enabled SRAM wrapper.
// Port 0 is the instruction side and port 1 is the data side.
// Grants are combinational. Each grant returns exactly one rvalid one cycle later.
// That rvalid is steered back to the port that issued the access.
module sp_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    prio_i,

  input  logic                    p0_req_i,
  output logic                    p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,

  input  logic                    p1_req_i,
  output logic                    p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,

  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  // rr_q holds the last granted port. The other port wins the next conflict.
  logic rr_q, rr_d;
  logic rvalid_q, rvalid_d;
  logic owner_q, owner_d;

  // Grant selection: the only requester wins; on conflict, priority mode or the round-robin pointer decides.
  always_comb begin
    p0_gnt_o = 1'b0;
    p1_gnt_o = 1'b0;
    if (p0_req_i && p1_req_i) begin
      if (prio_i || rr_q) begin
        p0_gnt_o = 1'b1;
      end else begin
        p1_gnt_o = 1'b1;
      end
    end else if (p0_req_i) begin
      p0_gnt_o = 1'b1;
    end else if (p1_req_i) begin
      p1_gnt_o = 1'b1;
    end
  end

  // RAM drive: mux of the granted port's signals. All outputs are zero when idle.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (p0_gnt_o) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = p0_addr_i;
      ram_we_o    = p0_we_i;
      ram_be_o    = p0_be_i;
      ram_wdata_o = p0_wdata_i;
    end else if (p1_gnt_o) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = p1_addr_i;
      ram_we_o    = p1_we_i;
      ram_be_o    = BE_WIDTH'(p1_be_i);
      ram_wdata_o = p1_wdata_i;
    end
  end

  // Next state: the pointer follows every grant, and the response tracker records the owner.
  always_comb begin
    rr_d     = rr_q;
    owner_d  = owner_q;
    rvalid_d = p0_gnt_o | p1_gnt_o;
    if (p0_gnt_o) begin
      rr_d    = 1'b0;
      owner_d = 1'b0;
    end else if (p1_gnt_o) begin
      rr_d    = 1'b1;
      owner_d = 1'b1;
    end
  end

  // State registers. Reset clears any in-flight response.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_q     <= 1'b1;
      owner_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Responses: the RAM data fans out to both ports and is qualified by the owner's rvalid.
  assign p0_rvalid_o = rvalid_q & ~owner_q;
  assign p1_rvalid_o = rvalid_q &  owner_q;
  assign p0_rdata_o  = ram_rdata_i;
  assign p1_rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Testbench for sp_ram_arbiter. A behavioural single-port RAM sits behind the arbiter.
// The stimulus pushes expected responses into a scoreboard.
// A separate monitor pops and compares an entry on every rvalid.
module tb_sp_ram_arbiter;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  localparam logic [31:0] W0 = 32'hA5A5_0000;
  localparam logic [31:0] W1 = 32'h1111_0004;
  localparam logic [31:0] W2 = 32'h2222_0008;

  logic          clk;
  logic          rstn;
  logic          prio;
  logic          p0_req, p0_gnt, p0_we, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [BW-1:0] p0_be;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_gnt, p1_we, p1_rvalid;
  logic [AW-1:0] p1_addr;
  logic [BW-1:0] p1_be;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc_cnt   = 0;

  typedef struct {
    bit          port;
    bit          wr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rstn_i      (rstn),
    .prio_i      (prio),
    .p0_req_i    (p0_req),
    .p0_gnt_o    (p0_gnt),
    .p0_addr_i   (p0_addr),
    .p0_we_i     (p0_we),
    .p0_be_i     (p0_be),
    .p0_wdata_i  (p0_wdata),
    .p0_rvalid_o (p0_rvalid),
    .p0_rdata_o  (p0_rdata),
    .p1_req_i    (p1_req),
    .p1_gnt_o    (p1_gnt),
    .p1_addr_i   (p1_addr),
    .p1_we_i     (p1_we),
    .p1_be_i     (p1_be),
    .p1_wdata_i  (p1_wdata),
    .p1_rvalid_o (p1_rvalid),
    .p1_rdata_o  (p1_rdata),
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt++;

  // Behavioural single-port RAM. Reads are registered. Contents are preloaded while in reset.
  logic [31:0] mem [0:8191];
  logic [12:0] ram_idx;
  assign ram_idx = ram_addr[AW-1:2];

  always @(posedge clk) begin
    if (!rstn) begin
      mem[0]    <= W0;
      mem[1]    <= W1;
      mem[2]    <= W2;
      mem[16]   <= 32'hDEAD_BEEF;
      mem[8191] <= 32'h0000_0000;
    end else if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_idx];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Monitor: every rvalid must match the oldest expected response in port, cycle and read data.
  always @(negedge clk) begin
    if (rstn && (p0_rvalid || p1_rvalid)) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_rvalid: got p0=%0b p1=%0b expected none (t=%0t)",
                 p0_rvalid, p1_rvalid, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("rv_both", 64'(p0_rvalid & p1_rvalid), 64'd0);
        chk("rv_port", 64'(p1_rvalid), 64'(mon_e.port));
        chk("rv_cycle", 64'(cyc_cnt), 64'(mon_e.cyc));
        if (!mon_e.wr)
          chk("rv_data", 64'(mon_e.port ? p1_rdata : p0_rdata), 64'(mon_e.data));
      end
    end
  end

  // Checks one arbitration cycle against the expected grants and queues the expected responses.
  task automatic issue(input bit e0, input bit e1, input logic [31:0] d0,
                       input logic [31:0] d1, input string name);
    logic [AW-1:0] exp_addr;
    exp_t e;
    #1;
    chk({name, "_gnt0"}, 64'(p0_gnt), 64'(e0));
    chk({name, "_gnt1"}, 64'(p1_gnt), 64'(e1));
    chk({name, "_ram_en"}, 64'(ram_en), 64'(e0 | e1));
    exp_addr = e0 ? p0_addr : (e1 ? p1_addr : '0);
    chk({name, "_ram_addr"}, 64'(ram_addr), 64'(exp_addr));
    if (e0) begin
      e.port = 1'b0; e.wr = p0_we; e.data = d0; e.cyc = cyc_cnt + 1;
      sb.push_back(e);
    end
    if (e1) begin
      e.port = 1'b1; e.wr = p1_we; e.data = d1; e.cyc = cyc_cnt + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; prio = 1'b0;
    p0_req = 1'b0; p0_addr = '0; p0_we = 1'b0; p0_be = 4'hF; p0_wdata = '0;
    p1_req = 1'b0; p1_addr = '0; p1_we = 1'b0; p1_be = 4'hF; p1_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt0", 64'(p0_gnt), 64'd0);
    chk("rst_gnt1", 64'(p1_gnt), 64'd0);
    chk("rst_rv0", 64'(p0_rvalid), 64'd0);
    chk("rst_rv1", 64'(p1_rvalid), 64'd0);
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    rstn = 1'b1;

    // Round-robin conflict from reset: p0 wins first, then the ports alternate.
    p0_req = 1'b1; p0_addr = 15'h0000;
    p1_req = 1'b1; p1_addr = 15'h0004;
    for (int i = 0; i < 6; i++) issue(i % 2 == 0, i % 2 == 1, W0, W1, "rr");
    p0_req = 1'b0; p1_req = 1'b0;
    issue(1'b0, 1'b0, '0, '0, "idle0");

    // Single-port read.
    p0_req = 1'b1; p0_addr = 15'h0040;
    #1;
    chk("rd_ram_we", 64'(ram_we), 64'd0);
    issue(1'b1, 1'b0, 32'hDEAD_BEEF, '0, "rd");
    p0_req = 1'b0;
    issue(1'b0, 1'b0, '0, '0, "idle1");

    // Byte-enabled write, then read back from the same address.
    p1_req = 1'b1; p1_addr = 15'h7FFC; p1_we = 1'b1; p1_be = 4'b0101; p1_wdata = 32'h1122_3344;
    #1;
    chk("wr_ram_we", 64'(ram_we), 64'd1);
    chk("wr_ram_be", 64'(ram_be), 64'h5);
    chk("wr_ram_wdata", 64'(ram_wdata), 64'h1122_3344);
    issue(1'b0, 1'b1, '0, '0, "wr");
    p1_we = 1'b0; p1_be = 4'hF; p1_wdata = '0;
    issue(1'b0, 1'b1, '0, 32'h0022_0044, "rdback");
    p1_req = 1'b0;
    issue(1'b0, 1'b0, '0, '0, "idle2");

    // Priority mode starves p1 until p0 drops its request.
    prio = 1'b1;
    p0_req = 1'b1; p0_addr = 15'h0000;
    p1_req = 1'b1; p1_addr = 15'h0004;
    repeat (4) issue(1'b1, 1'b0, W0, W1, "prio");
    p0_req = 1'b0;
    issue(1'b0, 1'b1, W0, W1, "prio_p1");
    p1_req = 1'b0; prio = 1'b0;
    issue(1'b0, 1'b0, '0, '0, "idle3");

    // Back-to-back reads from p0.
    p0_req = 1'b1;
    p0_addr = 15'h0000; issue(1'b1, 1'b0, W0, '0, "b2b0");
    p0_addr = 15'h0004; issue(1'b1, 1'b0, W1, '0, "b2b1");
    p0_addr = 15'h0008; issue(1'b1, 1'b0, W2, '0, "b2b2");
    p0_req = 1'b0;
    issue(1'b0, 1'b0, '0, '0, "idle4");
    issue(1'b0, 1'b0, '0, '0, "idle5");

    // Reset in the cycle after a p1 grant kills the pending rvalid.
    p1_req = 1'b1; p1_addr = 15'h0040;
    #1;
    chk("kill_gnt1", 64'(p1_gnt), 64'd1);
    @(posedge clk);
    #1;
    rstn = 1'b0; p1_req = 1'b0;
    #1;
    chk("kill_rv1", 64'(p1_rvalid), 64'd0);
    chk("kill_rv0", 64'(p0_rvalid), 64'd0);
    chk("kill_ram_en", 64'(ram_en), 64'd0);
    chk("kill_gnt", 64'({p0_gnt, p1_gnt}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    p0_req = 1'b1; p0_addr = 15'h0000;
    p1_req = 1'b1; p1_addr = 15'h0004;
    issue(1'b1, 1'b0, W0, W1, "post_rst");
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (3) issue(1'b0, 1'b0, '0, '0, "idle6");

    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Two-port round-robin arbiter that shares a single-port, byte-enabled SRAM macro wrapper between an instruction-side and a data-side requester. It sits directly in front of the single-port RAM wrapper (one read/write per cycle, registered bank select, read data valid one cycle after the access) and presents a req/gnt/rvalid handshake to each requester. It serialises conflicting accesses and returns responses to the port that issued them.

## Interface

**Parameters**
- `ADDR_WIDTH`, 15: byte address width; matches 32 KiB RAM.
- `DATA_WIDTH`, 32: data width; byte enables are `DATA_WIDTH/8`.

**Ports**
- `clk`, in, 1: single clock, rising edge.
- `rstn_i`, in, 1: reset; asynchronous, active-low.
- `prio_i`, in, 1: 1 = fixed priority to port 0; 0 = round-robin.
- `p0_req_i`, in, 1: port 0 (instruction) request.
- `p0_gnt_o`, out, 1: port 0 grant, combinational.
- `p0_addr_i`, in, ADDR_WIDTH: port 0 address.
- `p0_we_i`, in, 1: port 0 write enable.
- `p0_be_i`, in, DATA_WIDTH/8: port 0 byte enables.
- `p0_wdata_i`, in, DATA_WIDTH: port 0 write data.
- `p0_rvalid_o`, out, 1: port 0 response valid.
- `p0_rdata_o`, out, DATA_WIDTH: port 0 read data.
- `p1_*`: same set of signals for port 1 (data).
- `ram_en_o`, out, 1: RAM access enable.
- `ram_addr_o`, out, ADDR_WIDTH: RAM address.
- `ram_we_o`, out, 1: RAM write enable.
- `ram_be_o`, out, DATA_WIDTH/8: RAM byte enables.
- `ram_wdata_o`, out, DATA_WIDTH: RAM write data.
- `ram_rdata_i`, in, DATA_WIDTH: RAM read data, valid the cycle after the access.

## Operation

- **Handshake.** A requester holds `req`, `addr`, `we`, `be` and `wdata` stable until it samples `gnt`=1 on a rising edge. The transfer happens in the grant cycle. A requester may drop `req` only after it has been granted.
- **Grant.** At most one `gnt` per cycle.
  - Only one port requesting: that port is granted.
  - Both requesting, `prio_i`=1: port 0 is granted.
  - Both requesting, `prio_i`=0: grant the port not equal to `rr_q`.
  - No request: no grant, and `ram_en_o`=0.
- **Round-robin pointer.** `rr_q` holds the last granted port. It updates on every grant in both modes. Reset value 1, so port 0 wins the first conflict.
- **RAM drive.** The `ram_*` outputs are a combinational mux of the granted port's signals, with `ram_en_o` = any grant. When idle, `ram_addr_o`, `ram_be_o`, `ram_wdata_o` = 0 and `ram_we_o` = 0.
- **Response tracking.** `rvalid_q` and `owner_q` are registered from the grant. The next cycle, `pX_rvalid_o` = `rvalid_q & (owner_q==X)`.
  - Every granted transaction gets exactly one rvalid, reads and writes alike.
  - For writes, rdata is don't-care.
- **Read data.** `p0_rdata_o` = `p1_rdata_o` = `ram_rdata_i`. Data is qualified only by rvalid.
- **Pipelining.** Back-to-back grants are allowed: a grant in cycle N+1 coexists with the rvalid for the cycle-N grant. There is no outstanding-request limit beyond one per cycle.
- **Write-then-read to the same address.** A read granted in cycle N+1 returns the data written in cycle N. The RAM provides this; the arbiter adds no forwarding.

## Timing

- **Reset values:** all `gnt`, `rvalid`, `ram_en_o`, `ram_we_o` = 0; `rr_q`=1; `owner_q`=0; `rvalid_q`=0.
- **Latency:**
  - Grant: 0 cycles when uncontended.
  - Response: 1 cycle after grant.
  - Contended port: granted within 1 cycle in round-robin mode. In priority mode it is unbounded while port 0 keeps requesting.
- **Reset mid-operation:** asserting `rstn_i` in the cycle after a grant kills the pending rvalid. It is never emitted after reset release.
- **Toggling `prio_i`:** takes effect in the same cycle, because the grant is combinational. `rr_q` is not reset by the toggle.
- **Combinational paths:**
  - `req` → `gnt` and `req` → `ram_*` are combinational.
  - `ram_rdata_i` → `pX_rdata_o` is combinational.
  - No path from `ram_rdata_i` to `gnt`.

## Test plan

- **Single-port read.** Preload RAM word 0x10 = 0xDEADBEEF. Drive p0 read at addr 0x0040. Expect: `p0_gnt_o`=1 same cycle; `p0_rvalid_o`=1 next cycle with rdata 0xDEADBEEF; `p1_rvalid_o`=0 throughout.
- **Byte write then read.** p1 writes 0x11223344 with be=4'b0101 to addr 0x7FFC over RAM holding 0. Then p1 reads the same address. Expect: rvalid for both transactions; read data = 0x00220044.
- **Round-robin conflict.** Both ports request continuously for 6 cycles, `prio_i`=0, from reset. Expect grant order p0,p1,p0,p1,p0,p1; each rvalid one cycle after its grant with the correct owner.
- **Priority mode.** `prio_i`=1, both request for 4 cycles. Expect p0 granted all 4 cycles and p1 starved. Then drop p0 req: p1 is granted in the next cycle.
- **Back-to-back pipelining.** p0 reads at 0x0000, 0x0004, 0x0008 in consecutive cycles. Expect three consecutive rvalids, in order, with the preloaded words.
- **Reset mid-transaction.** Grant a p1 read, then assert `rstn_i`=0 the following cycle before the clock edge. Expect `p1_rvalid_o`=0 and all outputs at reset values. After release, the first conflict grants p0.
